reg_timer: RTL
==============

REG_TIMER -- requirements
Module: reg_timer

Interface
REQ-001 Parameter XLEN, default 32: register bus data width; only 32 supported.
REQ-002 Parameter ID_VALUE, default 32'h544D_5231: constant returned by the ID register.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rstb  input  1: asynchronous, active-low reset.
REQ-005 Port reg_addr  input  16: word-aligned byte offset within the block; bits [1:0] ignored.
REQ-006 Port reg_wr_en  input  1: single-cycle write strobe.
REQ-007 Port reg_wr_be  input  XLEN/8: per-byte write enables; bit i covers data bits [8i+7:8i].
REQ-008 Port reg_wr_data  input  XLEN: write data.
REQ-009 Port reg_rd_en  input  1: single-cycle read strobe.
REQ-010 Port reg_rd_data  output  XLEN: read data, valid when reg_rd_ready=1.
REQ-011 Port reg_rd_ready  output  1: one-cycle read-complete pulse.
REQ-012 Port irq  output  1: level interrupt request.

Function
REQ-013 Register map (offset, access, fields):
- 0x00 CTRL RW: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; other bits read 0.
- 0x04 PRESCALE RW: bits[15:0]; other bits read 0.
- 0x08 COUNT RW: 32-bit counter.
- 0x0C COMPARE RW: 32-bit.
- 0x10 STATUS W1C: bit0 MATCH, bit1 OVF; other bits read 0.
- 0x14 ID RO: ID_VALUE.
REQ-014 Unmapped offsets read 0; writes to them and to ID are ignored.
REQ-015 Writes apply only to bytes with reg_wr_be set; read-only and reserved bits are unaffected.
REQ-016 Read latency: reg_rd_en sampled high in cycle N -> reg_rd_ready=1 and reg_rd_data valid in cycle N+1 only; reg_rd_ready=0 otherwise.
REQ-017 reg_rd_data holds the last read value until the next read completes.
REQ-018 A read and a write in the same cycle: the write takes effect; the read returns the pre-write value.
REQ-019 Back-to-back reads on consecutive cycles: each returns its data with its own reg_rd_ready pulse.
REQ-020 Prescaler: pcnt (16-bit) increments each cycle while EN=1; when pcnt==PRESCALE it generates a one-cycle tick and returns to 0.
REQ-021 EN=0: pcnt is forced to 0 and no ticks occur; any write to PRESCALE clears pcnt to 0.
REQ-022 On tick with COUNT==COMPARE: MATCH is set; COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
REQ-023 On tick with COUNT!=COMPARE: COUNT becomes COUNT+1 modulo 2^32.
REQ-024 On tick with COUNT==32'hFFFF_FFFF and no reload: COUNT wraps to 0 and OVF is set.
REQ-025 A software write to COUNT in a tick cycle: the written bytes win, the tick is dropped, and no MATCH/OVF is set from it.
REQ-026 Hardware set and W1C clear of the same STATUS bit in one cycle: the set wins.
REQ-027 irq = IRQ_EN & (MATCH | OVF), driven only from registered state, with no combinational path from the inputs.

Reset
REQ-028 On rstb low, asynchronously: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, pcnt=0, reg_rd_data=0, reg_rd_ready=0, irq=0.
REQ-029 Reset asserted mid-read: no reg_rd_ready pulse occurs after reset is released.
REQ-030 No bus access is accepted while rstb is low.

Verification
REQ-031 Read ID at 0x14 -> reg_rd_ready pulses exactly one cycle later with 32'h544D_5231; a read of 0x18 returns 0.
REQ-032 Write COUNT=0x12345678 with be=4'b0101, then read -> 0x00340078.
REQ-033 PRESCALE=3, COMPARE=5, CTRL=0x7 -> COUNT advances every 4 cycles; MATCH and irq rise at the tick seen with COUNT=5; COUNT then returns to 0; writing STATUS=1 clears irq.
REQ-034 COUNT=0xFFFFFFFE, PRESCALE=0, CTRL=0x5 -> after 2 ticks COUNT=0, OVF=1, irq=1.
REQ-035 A COUNT write issued in the same cycle as a tick where COUNT==COMPARE -> COUNT equals the written value and MATCH stays 0.
REQ-036 rstb pulsed low while EN=1 and a read is outstanding -> all registers at reset values and no reg_rd_ready pulse after release.

Source files
------------

// File: rtl/reg_timer.sv
// Register-mapped prescaled timer with compare match, overflow status and a level IRQ.
// Bus reads complete one cycle after the strobe; writes are byte-enabled.
module reg_timer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] ID_VALUE = 32'h544D_5231
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [15:0]       reg_addr,
  input  logic              reg_wr_en,
  input  logic [XLEN/8-1:0] reg_wr_be,
  input  logic [XLEN-1:0]   reg_wr_data,
  input  logic              reg_rd_en,
  output logic [XLEN-1:0]   reg_rd_data,
  output logic              reg_rd_ready,
  output logic              irq
);
  localparam int BW = XLEN / 8;

  logic [2:0]      ctrl;
  logic [15:0]     prescale;
  logic [XLEN-1:0] count;
  logic [XLEN-1:0] compare;
  logic [1:0]      status;
  logic [15:0]     pcnt;

  function automatic logic [XLEN-1:0] bmerge(input logic [XLEN-1:0] old,
                                             input logic [XLEN-1:0] data,
                                             input logic [BW-1:0]   be);
    logic [XLEN-1:0] r;
    r = old;
    for (int i = 0; i < BW; i++)
      if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  logic [13:0] widx;
  logic        unused_addr;
  assign widx        = reg_addr[15:2];
  assign unused_addr = ^reg_addr[1:0];

  logic wr_ctrl, wr_pre, wr_count, wr_cmp, wr_stat;
  assign wr_ctrl  = reg_wr_en && (widx == 14'd0);
  assign wr_pre   = reg_wr_en && (widx == 14'd1);
  assign wr_count = reg_wr_en && (widx == 14'd2);
  assign wr_cmp   = reg_wr_en && (widx == 14'd3);
  assign wr_stat  = reg_wr_en && (widx == 14'd4);

  logic [XLEN-1:0] ctrl_w, pre_w;
  assign ctrl_w = bmerge({{(XLEN-3){1'b0}}, ctrl}, reg_wr_data, reg_wr_be);
  assign pre_w  = bmerge({{(XLEN-16){1'b0}}, prescale}, reg_wr_data, reg_wr_be);

  // A COUNT write in a tick cycle swallows the tick and its status side effects.
  logic tick, tick_eff, hit, reload, wrap;
  assign tick     = ctrl[0] && (pcnt == prescale);
  assign tick_eff = tick && !wr_count;
  assign hit      = (count == compare);
  assign reload   = hit && ctrl[1];
  assign wrap     = (count == '1) && !reload;

  logic [1:0] st_set, st_clr;
  assign st_set = {tick_eff && wrap, tick_eff && hit};
  assign st_clr = (wr_stat && reg_wr_be[0]) ? reg_wr_data[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ctrl     <= '0;
      prescale <= '0;
      count    <= '0;
      compare  <= '1;
      status   <= '0;
      pcnt     <= '0;
    end else begin
      if (wr_ctrl) ctrl     <= ctrl_w[2:0];
      if (wr_pre)  prescale <= pre_w[15:0];
      if (wr_cmp)  compare  <= bmerge(compare, reg_wr_data, reg_wr_be);
      if (wr_count)      count <= bmerge(count, reg_wr_data, reg_wr_be);
      else if (tick)     count <= reload ? '0 : count + 1'b1;
      status <= (status & ~st_clr) | st_set;
      if (!ctrl[0] || wr_pre || tick) pcnt <= '0;
      else                            pcnt <= pcnt + 16'd1;
    end
  end

  logic [XLEN-1:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (widx)
      14'd0: rd_mux = {{(XLEN-3){1'b0}}, ctrl};
      14'd1: rd_mux = {{(XLEN-16){1'b0}}, prescale};
      14'd2: rd_mux = count;
      14'd3: rd_mux = compare;
      14'd4: rd_mux = {{(XLEN-2){1'b0}}, status};
      14'd5: rd_mux = ID_VALUE;
      default: rd_mux = '0;
    endcase
  end

  // Read data samples pre-write state, so a same-cycle write is not visible.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      reg_rd_data  <= '0;
      reg_rd_ready <= 1'b0;
    end else begin
      reg_rd_ready <= reg_rd_en;
      if (reg_rd_en) reg_rd_data <= rd_mux;
    end
  end

  assign irq = ctrl[2] && (|status);
endmodule
